sram_1rw_arbiter: RTL and testbench
===================================

SRAM_1RW_ARBITER -- requirements
Module: sram_1rw_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: SRAM address width.
REQ-002 Parameter DATA_W, default 64: SRAM data width.
REQ-003 Parameter WAIT_MAX, default 4, range 1..15: maximum cycles a pending write may lose arbitration.
REQ-004 clock  in  1: single clock; all state updates on rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 rd_req_valid  in  1: read request pending.
REQ-007 rd_req_ready  out  1: read granted this cycle.
REQ-008 rd_req_addr  in  ADDR_W: read address.
REQ-009 rd_resp_valid  out  1: read data valid this cycle.
REQ-010 rd_resp_data  out  DATA_W: read data.
REQ-011 wr_req_valid  in  1: write request pending.
REQ-012 wr_req_ready  out  1: write granted this cycle.
REQ-013 wr_req_addr  in  ADDR_W: write address.
REQ-014 wr_req_data  in  DATA_W: write data.
REQ-015 mem_en  out  1: SRAM RW0 enable.
REQ-016 mem_wmode  out  1: SRAM RW0 write mode (1 = write).
REQ-017 mem_addr  out  ADDR_W: SRAM RW0 address.
REQ-018 mem_wdata  out  DATA_W: SRAM RW0 write data.
REQ-019 mem_rdata  in  DATA_W: SRAM RW0 read data, valid one cycle after a read access.

Function
REQ-020 At most one of rd_req_ready and wr_req_ready is high in any cycle; a grant is a combinational function of the valids and the current wait count.
REQ-021 Arbitration: the read is granted when rd_req_valid is high and wait_cnt < WAIT_MAX; otherwise the write is granted when wr_req_valid is high.
REQ-022 wait_cnt (4 bits) increments by 1 in each cycle that wr_req_valid is high and the write is not granted; it saturates at WAIT_MAX.
REQ-023 wait_cnt clears to 0 on any cycle with a write grant, and in any cycle with wr_req_valid low.
REQ-024 On a read grant: mem_en=1, mem_wmode=0, mem_addr=rd_req_addr.
REQ-025 On a write grant: mem_en=1, mem_wmode=1, mem_addr=wr_req_addr, mem_wdata=wr_req_data.
REQ-026 With no grant: mem_en=0, mem_wmode=0, mem_addr=0, mem_wdata=0.
REQ-027 rd_resp_valid is a register set to 1 exactly in the cycle after a read grant, and 0 otherwise; back-to-back grants give back-to-back valids.
REQ-028 When rd_resp_valid=1, rd_resp_data = mem_rdata; a hold register captures mem_rdata in that cycle.
REQ-029 When rd_resp_valid=0, rd_resp_data = hold register.
REQ-030 Read latency is exactly 1 cycle from grant. No response backpressure is supported; the requester always accepts rd_resp_valid.
REQ-031 Same-address read and write in one cycle are ordered by grant. A read granted first returns the old data. A write granted first makes the following read return the new data.
REQ-032 Requests are not latched internally; an ungranted requester holds valid, addr and data stable until it is granted.

Reset
REQ-033 Reset clears wait_cnt, rd_resp_valid and the hold register to 0. It takes effect asynchronously and deasserts synchronously to clock.
REQ-034 While reset is high: all outputs are 0, and no grant or SRAM access occurs.
REQ-035 Reset asserted mid-operation discards any in-flight read response; no rd_resp_valid is issued for it after reset.

Structure
REQ-036 Package sram_arb_pkg holds the ADDR_W/DATA_W/WAIT_MAX defaults and the wait-count width constant (4).
REQ-037 One sub-module, sram_arb_wait_ctr, holds the saturating wait counter with inc/clr inputs and an at_max output; the rest stays flat.

Verification (WAIT_MAX=4)
REQ-038 Read only: rd addr 0x005 granted in cycle t -> mem_en=1, mem_wmode=0 in cycle t; rd_resp_valid=1 with mem_rdata in t+1; data held in t+2.
REQ-039 Write only: wr addr 0x1FF, data 0xDEADBEEF_00000001 -> wr_req_ready=1 the same cycle; mem_wmode=1, mem_addr=0x1FF.
REQ-040 Continuous reads plus a held write -> reads granted for 4 cycles, write granted in cycle 5, reads resume in cycle 6; wait_cnt returns to 0.
REQ-041 Write then read to 0x010 -> the read response returns the written data; read first returns the old value.
REQ-042 Reset asserted in the cycle after a read grant -> rd_resp_valid=0, rd_resp_data=0, wait_cnt=0, with no spurious valid after release.
REQ-043 Random valids for 10k cycles -> never two grants at once, no write waits more than WAIT_MAX cycles, and every read grant yields exactly one response.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared defaults for the single-port SRAM read/write arbiter.
package sram_arb_pkg;
    localparam int ARB_ADDR_W   = 9;
    localparam int ARB_DATA_W   = 64;
    localparam int ARB_WAIT_MAX = 4;
    localparam int WAIT_CNT_W   = 4;
endpackage

// File: rtl/sram_arb_wait_ctr.sv
// Saturating count of cycles a pending write has lost arbitration to reads.
module sram_arb_wait_ctr
    import sram_arb_pkg::*;
#(
    parameter int WIDTH = WAIT_CNT_W,
    parameter int MAX   = ARB_WAIT_MAX
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !at_max) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign at_max = (count_reg >= MAX_V);
endmodule

// File: rtl/sram_1rw_arbiter.sv
// Read-priority arbiter for one RW SRAM port; a starved write wins after WAIT_MAX lost cycles.
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int WAIT_MAX = ARB_WAIT_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic              at_max;
    logic              rd_grant;
    logic              wr_grant;
    logic              wait_inc;
    logic              resp_valid_reg;
    logic [DATA_W-1:0] hold_reg;

    // Grants are suppressed while reset is held so no SRAM access leaks out.
    assign rd_grant = !reset && rd_req_valid && !at_max;
    assign wr_grant = !reset && !rd_grant && wr_req_valid;
    assign wait_inc = wr_req_valid && !wr_grant;

    sram_arb_wait_ctr #(
        .WIDTH (WAIT_CNT_W),
        .MAX   (WAIT_MAX)
    ) u_wait_ctr (
        .clock  (clock),
        .reset  (reset),
        .inc    (wait_inc),
        .clr    (!wait_inc),
        .at_max (at_max)
    );

    assign rd_req_ready = rd_grant;
    assign wr_req_ready = wr_grant;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_grant) begin
            mem_en   = 1'b1;
            mem_addr = rd_req_addr;
        end else if (wr_grant) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = wr_req_addr;
            mem_wdata = wr_req_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_reg <= 1'b0;
            hold_reg       <= '0;
        end else begin
            resp_valid_reg <= rd_grant;
            if (resp_valid_reg) begin
                hold_reg <= mem_rdata;
            end
        end
    end

    assign rd_resp_valid = resp_valid_reg;
    assign rd_resp_data  = resp_valid_reg ? mem_rdata : hold_reg;
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: directed cases, then random traffic against a reference model.
module tb_sram_1rw_arbiter;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 64;
    localparam int WAIT_MAX = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              mem_en;
    logic              mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    sram_1rw_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .mem_en        (mem_en),
        .mem_wmode     (mem_wmode),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // SRAM stand-in driven by the DUT's port; ref_mem is the model's own view of contents.
    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    initial begin
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 64'h1111_0000_0000_0000 + 64'(i);
            ref_mem[i] = 64'h1111_0000_0000_0000 + 64'(i);
        end
    end

    always @(posedge clock) begin
        if (mem_en && mem_wmode) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: read priority unless the write has already lost WAIT_MAX times.
    int                m_cnt = 0;
    logic              m_rv = 1'b0;
    logic [DATA_W-1:0] m_pdata = '0;
    logic [DATA_W-1:0] m_hold = '0;

    initial begin
        logic s_rst, s_rv, s_wv, e_rg, e_wg;
        logic [ADDR_W-1:0] s_ra, s_wa, e_addr;
        logic [DATA_W-1:0] s_wd, e_wdata, e_rdata;
        forever begin
            @(negedge clock);
            s_rst = reset;
            s_rv = rd_req_valid; s_ra = rd_req_addr;
            s_wv = wr_req_valid; s_wa = wr_req_addr; s_wd = wr_req_data;
            e_rg = !s_rst && s_rv && (m_cnt < WAIT_MAX);
            e_wg = !s_rst && !e_rg && s_wv;
            e_addr  = e_rg ? s_ra : (e_wg ? s_wa : '0);
            e_wdata = e_wg ? s_wd : '0;
            e_rdata = s_rst ? '0 : (m_rv ? m_pdata : m_hold);
            check("m_rd_ready", 64'(rd_req_ready), 64'(e_rg));
            check("m_wr_ready", 64'(wr_req_ready), 64'(e_wg));
            check("m_mem_en", 64'(mem_en), 64'(e_rg || e_wg));
            check("m_mem_wmode", 64'(mem_wmode), 64'(e_wg));
            check("m_mem_addr", 64'(mem_addr), 64'(e_addr));
            check("m_mem_wdata", mem_wdata, e_wdata);
            check("m_resp_valid", 64'(rd_resp_valid), 64'(!s_rst && m_rv));
            check("m_resp_data", rd_resp_data, e_rdata);
            @(posedge clock);
            if (s_rst) begin
                m_cnt = 0; m_rv = 1'b0; m_hold = '0;
            end else begin
                if (m_rv) m_hold = m_pdata;
                m_rv = e_rg;
                if (e_rg) m_pdata = ref_mem[s_ra];
                if (e_wg) ref_mem[s_wa] = s_wd;
                if (e_wg || !s_wv) m_cnt = 0;
                else if (m_cnt < WAIT_MAX) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic g_r, g_w;
        int wr_wait;
        reset = 1'b1;
        rd_req_valid = 1'b1; rd_req_addr = 9'h003;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;

        // Reset: a pending read must not be granted
        @(negedge clock);
        check("rst_rd_ready", 64'(rd_req_ready), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_resp_data", rd_resp_data, 64'd0);
        tick(); rd_req_valid = 1'b0;
        tick(); reset = 1'b0;

        // Read only, address 0x005
        rd_req_valid = 1'b1; rd_req_addr = 9'h005;
        @(negedge clock);
        check("rd_ready", 64'(rd_req_ready), 64'd1);
        check("rd_mem_wmode", 64'(mem_wmode), 64'd0);
        check("rd_mem_addr", 64'(mem_addr), 64'h005);
        tick(); rd_req_valid = 1'b0;
        @(negedge clock);
        check("rd_resp_valid", 64'(rd_resp_valid), 64'd1);
        check("rd_resp_data", rd_resp_data, 64'h1111_0000_0000_0005);
        tick();
        @(negedge clock);
        check("rd_resp_gone", 64'(rd_resp_valid), 64'd0);
        check("rd_resp_held", rd_resp_data, 64'h1111_0000_0000_0005);

        // Write only, address 0x1FF
        tick();
        wr_req_valid = 1'b1; wr_req_addr = 9'h1FF; wr_req_data = 64'hDEADBEEF_00000001;
        @(negedge clock);
        check("wr_ready", 64'(wr_req_ready), 64'd1);
        check("wr_mem_wmode", 64'(mem_wmode), 64'd1);
        check("wr_mem_addr", 64'(mem_addr), 64'h1FF);
        check("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_00000001);
        tick(); wr_req_valid = 1'b0;

        // Continuous reads with a held write: write wins in the fifth cycle
        rd_req_valid = 1'b1; rd_req_addr = 9'h040;
        wr_req_valid = 1'b1; wr_req_addr = 9'h041; wr_req_data = 64'h0000_0000_0000_CAFE;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            check($sformatf("starve_rd_c%0d", c), 64'(rd_req_ready), 64'(c != 5));
            check($sformatf("starve_wr_c%0d", c), 64'(wr_req_ready), 64'(c == 5));
            tick();
            if (c == 5) wr_req_valid = 1'b0;
        end
        rd_req_valid = 1'b0;
        tick();

        // Same address 0x010: read first sees old data, write first is then visible
        rd_req_valid = 1'b1; rd_req_addr = 9'h010;
        wr_req_valid = 1'b1; wr_req_addr = 9'h010; wr_req_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clock);
        check("raw_rd_first", 64'(rd_req_ready), 64'd1);
        tick(); rd_req_valid = 1'b0;
        @(negedge clock);
        check("raw_old_data", rd_resp_data, 64'h1111_0000_0000_0010);
        check("raw_wr_next", 64'(wr_req_ready), 64'd1);
        tick(); wr_req_valid = 1'b0; rd_req_valid = 1'b1;
        tick(); rd_req_valid = 1'b0;
        @(negedge clock);
        check("raw_new_data", rd_resp_data, 64'h0123_4567_89AB_CDEF);

        // Reset in the cycle after a read grant drops the response
        tick(); rd_req_valid = 1'b1; rd_req_addr = 9'h007;
        @(negedge clock);
        check("rr_grant", 64'(rd_req_ready), 64'd1);
        tick(); rd_req_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        check("rr_valid_in_rst", 64'(rd_resp_valid), 64'd0);
        check("rr_data_in_rst", rd_resp_data, 64'd0);
        tick(); reset = 1'b0;
        @(negedge clock);
        check("rr_valid_after", 64'(rd_resp_valid), 64'd0);
        check("rr_data_after", rd_resp_data, 64'd0);
        tick();

        // Random traffic; requesters hold until granted
        wr_wait = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!rd_req_valid) begin
                rd_req_valid = 1'($urandom_range(0, 1));
                rd_req_addr  = ADDR_W'($urandom_range(0, 31));
            end
            if (!wr_req_valid) begin
                wr_req_valid = 1'($urandom_range(0, 1));
                wr_req_addr  = ADDR_W'($urandom_range(0, 31));
                wr_req_data  = {$urandom, $urandom};
                wr_wait = 0;
            end
            reset = ($urandom_range(0, 999) == 0);
            @(negedge clock);
            g_r = rd_req_ready;
            g_w = wr_req_ready;
            check("one_grant", 64'(g_r && g_w), 64'd0);
            if (reset) begin
                wr_wait = 0;
            end else if (wr_req_valid) begin
                if (g_w) begin
                    check("wr_wait_bound", 64'(wr_wait > WAIT_MAX), 64'd0);
                    wr_wait = 0;
                end else begin
                    wr_wait++;
                end
            end
            tick();
            if (g_r) rd_req_valid = 1'b0;
            if (g_w) wr_req_valid = 1'b0;
        end
        reset = 1'b0; rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
